fx2_tx_arbiter: RTL and testbench

//  Owns the shared FX2 slave-FIFO bus in the fx2_clk domain and time-shares it between

---
 rtl/fx2_pkg.sv | 26 ++
 rtl/fx2_byte_serializer.sv | 40 ++++
 rtl/fx2_tx_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_fx2_tx_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx2_pkg.sv
// Shared constants and encodings for the FX2 slave-FIFO transmit arbiter.
package fx2_pkg;

  localparam logic [1:0] RX_EP_DEF     = 2'b00;
  localparam logic [1:0] REPLY_EP_DEF  = 2'b10;
  localparam logic [1:0] SAMPLE_EP_DEF = 2'b11;

  localparam int REPLY_BYTES  = 4;
  localparam int SAMPLE_BYTES = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RX     = 3'd1,
    ST_SELECT = 3'd2,
    ST_LOAD   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_PKTEND = 3'd5,
    ST_FLUSH  = 3'd6
  } arb_state_e;

  typedef enum logic {
    SRC_REPLY  = 1'b0,
    SRC_SAMPLE = 1'b1
  } src_e;

endpackage

// File: rtl/fx2_byte_serializer.sv
// Holds one N-byte word and presents it a byte at a time, LSB- or MSB-first.
module fx2_byte_serializer #(
  parameter int N_BYTES   = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                   fx2_clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [8*N_BYTES-1:0]   data,
  input  logic                   advance,
  output logic [7:0]             byte_out,
  output logic                   last
);

  localparam int IW = $clog2(N_BYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_BYTES - 1);

  logic [8*N_BYTES-1:0] word;
  logic [IW-1:0]        idx;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the async reset puts them in a known state without a clock.
  always_ff @(posedge fx2_clk or posedge reset) begin
    if (reset) begin
      word <= '0;
      idx  <= '0;
    end else if (load) begin
      word <= data;
      idx  <= '0;
    end else if (advance) begin
      word <= MSB_FIRST ? (word << 8) : (word >> 8);
      idx  <= idx + IW'(1);
    end
  end

  // The outgoing byte always sits at the end the word shifts away from.
  assign byte_out = MSB_FIRST ? word[8*N_BYTES-1 -: 8] : word[7:0];
  assign last     = (idx == LAST_IDX);

endmodule

// File: rtl/fx2_tx_arbiter.sv
// Time-shares the FX2 slave-FIFO bus between command receive, register replies
// and timetag samples; flushes partial sample packets after an idle timeout.
module fx2_tx_arbiter
  import fx2_pkg::*;
#(
  parameter logic [1:0]  RX_EP      = RX_EP_DEF,
  parameter logic [1:0]  REPLY_EP   = REPLY_EP_DEF,
  parameter logic [1:0]  SAMPLE_EP  = SAMPLE_EP_DEF,
  parameter int unsigned SETTLE     = 2,
  parameter int unsigned FLUSH_IDLE = 4096
) (
  input  logic        fx2_clk,
  input  logic        reset,
  input  logic [31:0] reply_data,
  input  logic        reply_valid,
  output logic        reply_ready,
  input  logic [47:0] sample_data,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic        rx_req,
  output logic        rx_gnt,
  input  logic        fx2_full_n,
  output logic [1:0]  fx2_fifoadr,
  output logic [7:0]  fx2_fd_out,
  output logic        fx2_fd_oe,
  output logic        fx2_slwr,
  output logic        fx2_pktend
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int IW = $clog2(FLUSH_IDLE);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [IW-1:0] IDLE_LAST   = IW'(FLUSH_IDLE - 1);

  arb_state_e    state;
  src_e          src;
  logic [SW-1:0] settle_cnt;
  logic [IW-1:0] idle_cnt;
  logic          sample_dirty;

  logic       write_fire;
  logic       last_byte;
  logic       reply_last;
  logic       sample_last;
  logic [7:0] reply_byte;
  logic [7:0] sample_byte;

  // slwr must follow full_n in the same cycle so a full FIFO never swallows a byte.
  assign write_fire = (state == ST_WRITE) && fx2_full_n;
  assign fx2_slwr   = ~write_fire;
  assign last_byte  = (src == SRC_REPLY) ? reply_last : sample_last;
  assign fx2_fd_out = (src == SRC_REPLY) ? reply_byte : sample_byte;

  fx2_byte_serializer #(
    .N_BYTES   (REPLY_BYTES),
    .MSB_FIRST (1'b0)
  ) u_reply_ser (
    .fx2_clk  (fx2_clk),
    .reset    (reset),
    .load     ((state == ST_LOAD) && (src == SRC_REPLY)),
    .data     (reply_data),
    .advance  (write_fire && (src == SRC_REPLY)),
    .byte_out (reply_byte),
    .last     (reply_last)
  );

  fx2_byte_serializer #(
    .N_BYTES   (SAMPLE_BYTES),
    .MSB_FIRST (1'b1)
  ) u_sample_ser (
    .fx2_clk  (fx2_clk),
    .reset    (reset),
    .load     ((state == ST_LOAD) && (src == SRC_SAMPLE)),
    .data     (sample_data),
    .advance  (write_fire && (src == SRC_SAMPLE)),
    .byte_out (sample_byte),
    .last     (sample_last)
  );

  always_ff @(posedge fx2_clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      src          <= SRC_REPLY;
      reply_ready  <= 1'b0;
      sample_ready <= 1'b0;
      rx_gnt       <= 1'b0;
      fx2_fifoadr  <= RX_EP;
      fx2_fd_oe    <= 1'b0;
      fx2_pktend   <= 1'b1;
      settle_cnt   <= '0;
      idle_cnt     <= '0;
      sample_dirty <= 1'b0;
    end else begin
      reply_ready  <= 1'b0;
      sample_ready <= 1'b0;
      fx2_pktend   <= 1'b1;

      unique case (state)
        ST_IDLE: begin
          settle_cnt <= '0;
          if (reply_valid) begin
            src         <= SRC_REPLY;
            fx2_fifoadr <= REPLY_EP;
            idle_cnt    <= '0;
            state       <= ST_SELECT;
          end else if (rx_req) begin
            rx_gnt      <= 1'b1;
            fx2_fifoadr <= RX_EP;
            idle_cnt    <= '0;
            state       <= ST_RX;
          end else if (sample_valid) begin
            src         <= SRC_SAMPLE;
            fx2_fifoadr <= SAMPLE_EP;
            idle_cnt    <= '0;
            state       <= ST_SELECT;
          end else if (sample_dirty) begin
            if (idle_cnt == IDLE_LAST) begin
              src         <= SRC_SAMPLE;
              fx2_fifoadr <= SAMPLE_EP;
              idle_cnt    <= '0;
              state       <= ST_FLUSH;
            end else begin
              idle_cnt <= idle_cnt + IW'(1);
            end
          end
        end

        ST_RX: begin
          if (!rx_req) begin
            rx_gnt <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        // Wait for the newly addressed FIFO's full flag to become trustworthy.
        ST_SELECT: begin
          if (settle_cnt == SETTLE_LAST) begin
            reply_ready  <= (src == SRC_REPLY);
            sample_ready <= (src == SRC_SAMPLE);
            fx2_fd_oe    <= 1'b1;
            state        <= ST_LOAD;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end

        ST_LOAD: state <= ST_WRITE;

        ST_WRITE: begin
          if (write_fire && last_byte) begin
            if (src == SRC_REPLY) begin
              fx2_pktend <= 1'b0;
              state      <= ST_PKTEND;
            end else begin
              sample_dirty <= 1'b1;
              fx2_fd_oe    <= 1'b0;
              state        <= ST_IDLE;
            end
          end
        end

        // Shared by reply commit and sample flush; src tells which one it was.
        ST_PKTEND: begin
          fx2_fd_oe <= 1'b0;
          if (src == SRC_SAMPLE) sample_dirty <= 1'b0;
          state <= ST_IDLE;
        end

        ST_FLUSH: begin
          if (settle_cnt == SETTLE_LAST) begin
            fx2_pktend <= 1'b0;
            state      <= ST_PKTEND;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fx2_tx_arbiter.sv
// Self-checking bench for fx2_tx_arbiter: bus events are compared against a
// scoreboard queue of expected writes and packet-end strobes.
module tb_fx2_tx_arbiter;

  localparam int unsigned SETTLE     = 2;
  localparam int unsigned FLUSH_IDLE = 32;
  localparam logic [1:0]  RXA = 2'b00;
  localparam logic [1:0]  REP = 2'b10;
  localparam logic [1:0]  SMP = 2'b11;

  logic        fx2_clk;
  logic        reset;
  logic [31:0] reply_data;
  logic        reply_valid;
  logic        reply_ready;
  logic [47:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        rx_req;
  logic        rx_gnt;
  logic        fx2_full_n;
  logic [1:0]  fx2_fifoadr;
  logic [7:0]  fx2_fd_out;
  logic        fx2_fd_oe;
  logic        fx2_slwr;
  logic        fx2_pktend;

  fx2_tx_arbiter #(
    .SETTLE     (SETTLE),
    .FLUSH_IDLE (FLUSH_IDLE)
  ) dut (
    .fx2_clk      (fx2_clk),
    .reset        (reset),
    .reply_data   (reply_data),
    .reply_valid  (reply_valid),
    .reply_ready  (reply_ready),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .rx_req       (rx_req),
    .rx_gnt       (rx_gnt),
    .fx2_full_n   (fx2_full_n),
    .fx2_fifoadr  (fx2_fifoadr),
    .fx2_fd_out   (fx2_fd_out),
    .fx2_fd_oe    (fx2_fd_oe),
    .fx2_slwr     (fx2_slwr),
    .fx2_pktend   (fx2_pktend)
  );

  initial fx2_clk = 1'b0;
  always #5 fx2_clk = ~fx2_clk;

  typedef struct packed {
    logic       pkt;
    logic [1:0] adr;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    bit          is_reply;
    logic [47:0] data;
    logic [47:0] exp_bytes;
  } vec_t;

  ev_t  exp_q[$];
  ev_t  mon_ev;
  vec_t vecs[5];
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;
  int   wr_count = 0;
  int   last_wr_cyc = 0;
  int   last_pkt_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge fx2_clk) cyc++;

  // Bus monitor: every write strobe and packet-end strobe must match the scoreboard.
  always @(negedge fx2_clk) begin
    if (!reset) begin
      if (rx_gnt) check("gnt_with_fd_oe", fx2_fd_oe, 0);
      if (!fx2_slwr) begin
        wr_count++;
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_write", exp_q.size(), 1);
        else begin
          mon_ev = exp_q.pop_front();
          check("write_kind", mon_ev.pkt, 0);
          check("write_adr", fx2_fifoadr, mon_ev.adr);
          check("write_data", fx2_fd_out, mon_ev.data);
          check("write_oe", fx2_fd_oe, 1);
        end
      end
      if (!fx2_pktend) begin
        last_pkt_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_pktend", exp_q.size(), 1);
        else begin
          mon_ev = exp_q.pop_front();
          check("pktend_kind", mon_ev.pkt, 1);
          check("pktend_adr", fx2_fifoadr, mon_ev.adr);
        end
      end
    end
  end

  task automatic step();
    @(negedge fx2_clk);
    #1;
  endtask

  task automatic push_bytes(input logic [1:0] adr, input logic [47:0] bytes, input int n);
    logic [47:0] b;
    ev_t e;
    b = bytes;
    for (int i = 0; i < n; i++) begin
      e.pkt  = 1'b0;
      e.adr  = adr;
      e.data = b[47:40];
      exp_q.push_back(e);
      b = b << 8;
    end
  endtask

  task automatic push_pkt(input logic [1:0] adr);
    ev_t e;
    e.pkt  = 1'b1;
    e.adr  = adr;
    e.data = 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
    check("drain", exp_q.size(), 0);
    repeat (3) step();
  endtask

  // Waits for the chosen ready pulse, returns its latency in cycles, then drops valid.
  task automatic wait_ready(input bit is_reply, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (is_reply ? reply_ready : sample_ready) begin
        n = i;
        break;
      end
    end
    @(posedge fx2_clk);
    #1;
    if (is_reply) begin
      reply_valid = 1'b0;
      check("reply_ready_pulse", reply_ready, 0);
    end else begin
      sample_valid = 1'b0;
      check("sample_ready_pulse", sample_ready, 0);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    if (v.is_reply) begin
      push_bytes(REP, v.exp_bytes, 4);
      push_pkt(REP);
      reply_data  = v.data[31:0];
      reply_valid = 1'b1;
      wait_ready(1'b1, 20, n);
      check("reply_latency", n, SETTLE + 1);
      drain(40);
    end else begin
      push_bytes(SMP, v.exp_bytes, 6);
      push_pkt(SMP);
      sample_data  = v.data;
      sample_valid = 1'b1;
      wait_ready(1'b0, 20, n);
      check("sample_latency", n, SETTLE + 1);
      drain(FLUSH_IDLE + 60);
      check("flush_gap", last_pkt_cyc - last_wr_cyc, FLUSH_IDLE + SETTLE + 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int   n;
    vec_t v;

    vecs[0] = '{1'b1, 48'h0000_0000_0002, 48'h02_00_00_00_00_00};
    vecs[1] = '{1'b0, 48'h0123_4567_89AB, 48'h01_23_45_67_89_AB};
    vecs[2] = '{1'b1, 48'h0000_DEAD_BEEF, 48'hEF_BE_AD_DE_00_00};
    vecs[3] = '{1'b0, 48'hFEDC_BA98_7654, 48'hFE_DC_BA_98_76_54};
    vecs[4] = '{1'b1, 48'h0000_1234_5678, 48'h78_56_34_12_00_00};

    reset        = 1'b1;
    reply_data   = '0;
    reply_valid  = 1'b0;
    sample_data  = '0;
    sample_valid = 1'b0;
    rx_req       = 1'b0;
    fx2_full_n   = 1'b1;
    repeat (3) step();
    check("rst_slwr", fx2_slwr, 1);
    check("rst_pktend", fx2_pktend, 1);
    check("rst_fd_oe", fx2_fd_oe, 0);
    check("rst_fifoadr", fx2_fifoadr, RXA);
    check("rst_fd_out", fx2_fd_out, 0);
    check("rst_ready", {reply_ready, sample_ready, rx_gnt}, 0);
    reset = 1'b0;
    repeat (2) step();

    // Table: replies and samples one at a time, including the idle flush.
    foreach (vecs[i]) run_vec(vecs[i]);

    // Reply and sample requested together: reply finishes (with pktend) first.
    push_bytes(REP, 48'h44_33_22_11_00_00, 4);
    push_pkt(REP);
    push_bytes(SMP, 48'hA0_A1_A2_A3_A4_A5, 6);
    push_pkt(SMP);
    reply_data   = 32'h1122_3344;
    sample_data  = 48'hA0A1_A2A3_A4A5;
    reply_valid  = 1'b1;
    sample_valid = 1'b1;
    wait_ready(1'b1, 20, n);
    check("both_reply_latency", n, SETTLE + 1);
    wait_ready(1'b0, 40, n);
    check("both_sample_seen", n > 0, 1);
    drain(FLUSH_IDLE + 60);

    // FIFO full for three cycles after the second sample byte.
    wr_count = 0;
    push_bytes(SMP, 48'hC0_C1_C2_C3_C4_C5, 6);
    push_pkt(SMP);
    sample_data  = 48'hC0C1_C2C3_C4C5;
    sample_valid = 1'b1;
    wait_ready(1'b0, 20, n);
    for (int i = 0; i < 20 && wr_count < 2; i++) step();
    @(posedge fx2_clk);
    #1;
    fx2_full_n = 1'b0;
    repeat (3) begin
      step();
      check("stall_slwr", fx2_slwr, 1);
      check("stall_count", wr_count, 2);
      @(posedge fx2_clk);
      #1;
    end
    fx2_full_n = 1'b1;
    drain(FLUSH_IDLE + 60);
    check("stall_total", wr_count, 6);

    // Receiver request during a sample record waits for the record to finish.
    wr_count = 0;
    push_bytes(SMP, 48'h5A_5B_5C_5D_5E_5F, 6);
    push_pkt(SMP);
    sample_data  = 48'h5A5B_5C5D_5E5F;
    sample_valid = 1'b1;
    wait_ready(1'b0, 20, n);
    for (int i = 0; i < 20 && wr_count < 1; i++) step();
    rx_req = 1'b1;
    for (int i = 0; i < 40 && !rx_gnt; i++) step();
    check("rx_gnt_after_record", wr_count, 6);
    check("rx_gnt_seen", rx_gnt, 1);
    check("rx_fifoadr", fx2_fifoadr, RXA);
    check("rx_fd_oe", fx2_fd_oe, 0);
    repeat (4) begin
      step();
      check("rx_hold", rx_gnt, 1);
    end
    rx_req = 1'b0;
    repeat (2) step();
    check("rx_release", rx_gnt, 0);
    drain(FLUSH_IDLE + 60);

    // Reset in the middle of a reply drops it; the next reply starts from byte 0.
    wr_count = 0;
    push_bytes(REP, 48'hD4_C3_00_00_00_00, 2);
    reply_data  = 32'hA1B2_C3D4;
    reply_valid = 1'b1;
    wait_ready(1'b1, 20, n);
    for (int i = 0; i < 20 && wr_count < 2; i++) step();
    reset = 1'b1;
    #1;
    check("midrst_slwr", fx2_slwr, 1);
    check("midrst_pktend", fx2_pktend, 1);
    check("midrst_fd_oe", fx2_fd_oe, 0);
    check("midrst_fifoadr", fx2_fifoadr, RXA);
    check("midrst_fd_out", fx2_fd_out, 0);
    check("midrst_queue", exp_q.size(), 0);
    step();
    reset = 1'b0;
    step();
    v = '{1'b1, 48'h0000_A1B2_C3D4, 48'hD4_C3_B2_A1_00_00};
    run_vec(v);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
